// File: rtl/shift_pkg.sv
// shift_pkg: op and FSM state encodings shared by seq_shifter and shift_step
package shift_pkg;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational single-cycle shift of a by amt (0..STEP) positions
// Ports: a (operand), op (SLL/SRL/SRA/ROR), amt (positions this cycle), y (shifted value)
// ROR logic exists only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise op=ROR passes a through.
module shift_step
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 1,
    parameter int AW   = $clog2(STEP + 1)
) (
    input  logic [N-1:0]  a,
    input  op_t           op,
    input  logic [AW-1:0] amt,
    output logic [N-1:0]  y
);
    // kept as its own signal so the arithmetic shift is not made unsigned by the select
    logic signed [N-1:0] sra;
    logic        [N-1:0] ror;
    assign sra = $signed(a) >>> amt;
`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [2*N-1:0] dbl;
    assign dbl = {a, a} >> amt;
    assign ror = dbl[N-1:0];
`else
    assign ror = a;
`endif
    always_comb begin
        y = op == OP_SLL ? a << amt :
            op == OP_SRL ? a >> amt :
            op == OP_SRA ? sra : ror;
    end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter moving at most STEP bit positions per clock
// Ports: clk, rst (async active-low), start, op (00 SLL, 01 SRL, 10 SRA, 11 ROR),
//        a, shamt -> busy (in SHIFT), done (one-cycle pulse), result (held until next start)
// Define SEQ_SHIFTER_ROTATE_EN to enable ROR; otherwise op=11 completes as a zero-amount shift.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [N-1:0]         a,
    input  logic [$clog2(N)-1:0] shamt,
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         result
);
    localparam int SW = $clog2(N);
    localparam int AW = $clog2(STEP + 1);
    // STEP may equal N, which needs one bit more than the remaining-count register
    localparam logic [SW:0] STEP_W = (SW + 1)'(STEP);
    state_t        state, state_n;
    op_t           op_q;
    logic [N-1:0]  work, step_y;
    logic [SW-1:0] rem, shamt_eff;
    logic [AW-1:0] amt;
    logic          accept, last;
`ifdef SEQ_SHIFTER_ROTATE_EN
    assign shamt_eff = shamt;
`else
    assign shamt_eff = op == OP_ROR ? '0 : shamt;
`endif
    assign accept = start && state != SHIFT;
    assign last   = {1'b0, rem} <= STEP_W;
    // when last, rem <= STEP so it fits in AW bits
    assign amt    = last ? AW'(rem) : AW'(STEP);
    shift_step #(.N(N), .STEP(STEP), .AW(AW)) u_step (
        .a  (work),
        .op (op_q),
        .amt(amt),
        .y  (step_y)
    );
    always_comb begin
        state_n = accept ? (shamt_eff != '0 ? SHIFT : DONE) :
                  state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_q  <= OP_SLL;
            work  <= '0;
            rem   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                work <= a;
                op_q <= op_t'(op);
                rem  <= shamt_eff;
            end else if (state == SHIFT) begin
                work <= step_y;
                rem  <= rem - SW'(amt);
            end
        end
    end
    assign busy   = state == SHIFT;
    assign done   = state == DONE;
    assign result = work;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench for seq_shifter with STEP=1 and STEP=4 instances
module tb_seq_shifter;
`ifdef SEQ_SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif
    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk, rst, start1, start4;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q1[$], q4[$];
    exp_t        e1, e4;

    seq_shifter #(.N(32), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .shamt(shamt),
        .busy(busy1), .done(done1), .result(res1)
    );
    seq_shifter #(.N(32), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .shamt(shamt),
        .busy(busy4), .done(done4), .result(res4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [31:0] v, input logic [1:0] o, input int sh);
        logic signed [31:0] s;
        logic [31:0] r;
        s = v;
        case (o)
            2'd0: r = v << sh;
            2'd1: r = v >> sh;
            2'd2: r = s >>> sh;
            default: r = ROT ? ((v >> sh) | (v << (32 - sh))) : v;
        endcase
        return r;
    endfunction

    function automatic int cycles(input logic [1:0] o, input int sh, input int stp);
        int e;
        e = (o == 2'd3 && !ROT) ? 0 : sh;
        return (e + stp - 1) / stp;
    endfunction

    // scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && done1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL u1_unexpected_done result=%h cycle=%0d", res1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (res1 !== e1.res || cyc != e1.cyc) begin
                    miscompares++;
                    $display("FAIL u1_result got %h at cycle %0d, expected %h at cycle %0d", res1, cyc, e1.res, e1.cyc);
                end
            end
        end
        if (rst && done4) begin
            vectors++;
            if (q4.size() == 0) begin
                miscompares++;
                $display("FAIL u4_unexpected_done result=%h cycle=%0d", res4, cyc);
            end else begin
                e4 = q4.pop_front();
                if (res4 !== e4.res || cyc != e4.cyc) begin
                    miscompares++;
                    $display("FAIL u4_result got %h at cycle %0d, expected %h at cycle %0d", res4, cyc, e4.res, e4.cyc);
                end
            end
        end
    end

    // called at a falling edge; start is held for exactly the next rising edge
    task automatic issue(input int sel, input logic [31:0] av, input logic [1:0] o, input int sh, input logic [31:0] er);
        exp_t e;
        e.res = er;
        e.cyc = cyc + 1 + cycles(o, sh, sel);
        a     = av;
        op    = o;
        shamt = 5'(sh);
        if (sel == 1) begin
            start1 = 1'b1;
            q1.push_back(e);
        end else begin
            start4 = 1'b1;
            q4.push_back(e);
        end
    endtask

    task automatic wait_done(input int sel, input int exp_busy);
        int b;
        bit seen;
        b = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            start4 = 1'b0;
            if (sel == 1 ? busy1 : busy4) b++;
            if (sel == 1 ? done1 : done4) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL wait_done_timeout dut=%0d no done within 100 cycles", sel);
        end else if (exp_busy >= 0 && b != exp_busy) begin
            miscompares++;
            $display("FAIL busy_cycles dut=%0d got %0d expected %0d", sel, b, exp_busy);
        end
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if ({busy1, done1, res1, busy4, done4, res4} !== 68'd0) begin
            miscompares++;
            $display("FAIL reset_state got b1=%b d1=%b r1=%h b4=%b d4=%b r4=%h expected all 0", busy1, done1, res1, busy4, done4, res4);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sll;
        issue(1, 32'h0000_0001, 2'd0, 5, 32'h0000_0020);
        wait_done(1, 5);
    endtask

    task automatic test_sra_srl;
        issue(4, 32'h8000_0000, 2'd2, 31, 32'hFFFF_FFFF);
        wait_done(4, 8);
        issue(4, 32'h8000_0000, 2'd1, 31, 32'h0000_0001);
        wait_done(4, 8);
        @(negedge clk);
    endtask

    task automatic test_zero;
        issue(1, 32'hDEAD_BEEF, 2'd1, 0, 32'hDEAD_BEEF);
        wait_done(1, 0);
        issue(4, 32'hDEAD_BEEF, 2'd1, 0, 32'hDEAD_BEEF);
        wait_done(4, 0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        issue(1, 32'h0000_0003, 2'd0, 4, 32'h0000_0030);
        @(negedge clk);
        start1 = 1'b0;
        a      = 32'hFFFF_FFFF;
        op     = 2'd1;
        shamt  = 5'd1;
        start1 = 1'b1;
        wait_done(1, -1);
        issue(1, 32'h0000_00F0, 2'd1, 4, 32'h0000_000F);
        wait_done(1, 4);
        repeat (3) @(negedge clk);
        vectors++;
        if (res1 !== 32'h0000_000F || done1 !== 1'b0) begin
            miscompares++;
            $display("FAIL result_hold got %h done=%b expected 0000000f done=0", res1, done1);
        end
    endtask

    task automatic test_reset_mid;
        int b;
        b = 0;
        issue(1, 32'h0000_0001, 2'd0, 20, 32'h0010_0000);
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        q1.delete();
        vectors++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || res1 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b done=%b result=%h expected 0 0 0", busy1, done1, res1);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (busy1) b++;
        end
        vectors++;
        if (b != 0) begin
            miscompares++;
            $display("FAIL after_reset_busy got %0d busy cycles expected 0", b);
        end
        issue(1, 32'h0000_0005, 2'd2, 2, 32'h0000_0001);
        wait_done(1, 2);
        @(negedge clk);
    endtask

    task automatic test_rotate;
        issue(1, 32'h0000_0001, 2'd3, 1, ROT ? 32'h8000_0000 : 32'h0000_0001);
        wait_done(1, ROT ? 1 : 0);
        issue(4, 32'h1234_5678, 2'd3, 8, model(32'h1234_5678, 2'd3, 8));
        wait_done(4, cycles(2'd3, 8, 4));
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [31:0] av;
        logic [1:0]  o;
        int          sh;
        for (int i = 0; i < 24; i++) begin
            av = $urandom;
            o  = 2'($urandom_range(0, 3));
            sh = $urandom_range(0, 31);
            issue(i % 2 == 0 ? 1 : 4, av, o, sh, model(av, o, sh));
            wait_done(i % 2 == 0 ? 1 : 4, cycles(o, sh, i % 2 == 0 ? 1 : 4));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        a      = '0;
        op     = '0;
        shamt  = '0;
        test_reset;
        test_sll;
        test_sra_srl;
        test_zero;
        test_back_to_back;
        test_reset_mid;
        test_rotate;
        test_random;
        vectors++;
        if (q1.size() != 0 || q4.size() != 0) begin
            miscompares++;
            $display("FAIL pending_results got %0d/%0d outstanding expected 0/0", q1.size(), q4.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
